// File: rtl/vote_pkg.sv
// vote_pkg
// Shared definitions for the vote_tally slice: the debounce channel state
// type, the default debounce length for the board clock, and a width helper
// that never returns zero so single-value counters still get one bit.
package vote_pkg;

  // 50 MHz board clock: one second of stable level accepts a press.
  localparam int DEBOUNCE_MAX = 50000000;

  // Phase of one debounce channel, decoded from its synchronised level and
  // its counter value.
  typedef enum logic [1:0] {
    DB_RELEASED = 2'd0,
    DB_COUNTING = 2'd1,
    DB_HELD     = 2'd2
  } db_state_e;

  // Bits needed to hold values 0 .. value-1, with a floor of one bit.
  function automatic int clog2_min1(input int value);
    if (value <= 2) begin
      return 1;
    end
    return $clog2(value);
  endfunction

endpackage

// File: rtl/vote_debounce.sv
// vote_debounce
// One candidate channel: a two-flop synchroniser for the raw button, a
// saturating debounce counter, and a one-shot accept strobe.
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   btn_i    raw asynchronous button level, active-high
//   accept_o single-cycle strobe in the cycle the counter reaches
//            DEBOUNCE_CYC (combinational, consumed on the next edge)
module vote_debounce
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic accept_o
);

  localparam int DB_W = clog2_min1(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [1:0]      sync_q, sync_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  db_state_e       db_state;
  logic            level_s;

  assign level_s = sync_q[1];

  // Synchroniser shift: bit 0 takes the raw pin, bit 1 is the safe level.
  always_comb begin
    sync_d = {sync_q[0], btn_i};
  end

  // Phase decode. The counter parks at DB_FULL while the level stays high,
  // which is what limits a held button to a single accepted press.
  always_comb begin
    db_state = DB_RELEASED;
    if (level_s) begin
      if (db_cnt_q == DB_FULL) begin
        db_state = DB_HELD;
      end else begin
        db_state = DB_COUNTING;
      end
    end
  end

  // Next counter value and the accept strobe.
  always_comb begin
    db_cnt_d = db_cnt_q;
    accept_o = 1'b0;
    case (db_state)
      DB_RELEASED: db_cnt_d = '0;
      DB_COUNTING: begin
        db_cnt_d = db_cnt_q + 1'b1;
        accept_o = (db_cnt_q == DB_LAST);
      end
      DB_HELD:     db_cnt_d = db_cnt_q;
      default:     db_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
    end
  end

endmodule

// File: rtl/vote_tally.sv
// vote_tally
// Parametrised voting machine: N_CAND debounced candidate buttons feed
// independent saturating vote counters. A registered running total, a
// selectable display and leader/tie detection drive the LED bank.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   btn          raw candidate buttons, active-high
//   vote_en      voting open; presses accepted while low are discarded
//   sel          display select, lowest set bit wins; zero shows the total
//   disp_out     registered display value
//   total_votes  registered sum of all counters
//   leader_idx   lowest index holding the maximum count
//   leader_valid at least one vote has been counted
//   tie          more than one candidate holds the maximum count
//   sat          sticky per-candidate saturation flags
//   vote_pulse   one-cycle pulse per counted vote
module vote_tally
  import vote_pkg::*;
#(
  parameter int N_CAND       = 4,
  parameter int CNT_W        = 8,
  parameter int DEBOUNCE_CYC = DEBOUNCE_MAX,
  localparam int IDX_W       = $clog2(N_CAND),
  localparam int TOT_W       = CNT_W + IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CAND-1:0] btn,
  input  logic              vote_en,
  input  logic [N_CAND-1:0] sel,
  output logic [CNT_W-1:0]  disp_out,
  output logic [TOT_W-1:0]  total_votes,
  output logic [IDX_W-1:0]  leader_idx,
  output logic              leader_valid,
  output logic              tie,
  output logic [N_CAND-1:0] sat,
  output logic [N_CAND-1:0] vote_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_CAND-1:0] accept;

  logic [CNT_W-1:0]  cnt_q [N_CAND];
  logic [CNT_W-1:0]  cnt_d [N_CAND];
  logic [N_CAND-1:0] sat_q, sat_d;
  logic [N_CAND-1:0] vote_pulse_q, vote_pulse_d;
  logic [TOT_W-1:0]  total_votes_q, total_votes_d;
  logic [CNT_W-1:0]  disp_out_q, disp_out_d;
  logic [IDX_W-1:0]  leader_idx_q, leader_idx_d;
  logic              leader_valid_q, leader_valid_d;
  logic              tie_q, tie_d;
  logic [CNT_W-1:0]  max_cnt;
  logic              other_at_max;

  for (genvar g = 0; g < N_CAND; g++) begin : g_chan
    vote_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn[g]),
      .accept_o(accept[g])
    );
  end

  // Vote counting. Every channel is handled independently so simultaneous
  // presses all land in the same cycle; a press at full scale only marks
  // the channel saturated and does not pulse.
  always_comb begin
    sat_d        = sat_q;
    vote_pulse_d = '0;
    for (int i = 0; i < N_CAND; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept[i] && vote_en) begin
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i]        = cnt_q[i] + 1'b1;
          vote_pulse_d[i] = 1'b1;
        end else begin
          sat_d[i] = 1'b1;
        end
      end
    end
  end

  // Running total. TOT_W carries IDX_W extra bits, enough for N_CAND
  // full-scale counters, so the sum never wraps.
  always_comb begin
    total_votes_d = '0;
    for (int i = 0; i < N_CAND; i++) begin
      total_votes_d = total_votes_d + TOT_W'(cnt_q[i]);
    end
  end

  // Display mux. Scanning from the top down lets the lowest set sel bit
  // overwrite the others. With no bit set the freshly summed total is shown,
  // clamped to the LED width, so it lines up with total_votes.
  always_comb begin
    if (total_votes_d > TOT_W'(CNT_MAX)) begin
      disp_out_d = CNT_MAX;
    end else begin
      disp_out_d = total_votes_d[CNT_W-1:0];
    end
    for (int i = N_CAND - 1; i >= 0; i--) begin
      if (sel[i]) begin
        disp_out_d = cnt_q[i];
      end
    end
  end

  // Leader search. The strict greater-than keeps the lowest index on equal
  // counts; a second pass flags any other index sharing that maximum. With
  // all counts zero max_cnt stays zero, which clears valid and tie.
  always_comb begin
    max_cnt      = '0;
    leader_idx_d = '0;
    other_at_max = 1'b0;
    for (int i = 0; i < N_CAND; i++) begin
      if (cnt_q[i] > max_cnt) begin
        max_cnt      = cnt_q[i];
        leader_idx_d = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_CAND; i++) begin
      if ((cnt_q[i] == max_cnt) && (IDX_W'(i) != leader_idx_d)) begin
        other_at_max = 1'b1;
      end
    end
    leader_valid_d = (max_cnt != '0);
    tie_d          = other_at_max && leader_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CAND; i++) begin
        cnt_q[i] <= '0;
      end
      sat_q          <= '0;
      vote_pulse_q   <= '0;
      total_votes_q  <= '0;
      disp_out_q     <= '0;
      leader_idx_q   <= '0;
      leader_valid_q <= 1'b0;
      tie_q          <= 1'b0;
    end else begin
      for (int i = 0; i < N_CAND; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sat_q          <= sat_d;
      vote_pulse_q   <= vote_pulse_d;
      total_votes_q  <= total_votes_d;
      disp_out_q     <= disp_out_d;
      leader_idx_q   <= leader_idx_d;
      leader_valid_q <= leader_valid_d;
      tie_q          <= tie_d;
    end
  end

  assign disp_out     = disp_out_q;
  assign total_votes  = total_votes_q;
  assign leader_idx   = leader_idx_q;
  assign leader_valid = leader_valid_q;
  assign tie          = tie_q;
  assign sat          = sat_q;
  assign vote_pulse   = vote_pulse_q;

endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally
// Directed bench for vote_tally with a short debounce window. Inputs change
// and outputs are sampled on the falling clock edge; a monitor counts
// vote_pulse events per channel so pulse totals can be compared.
module tb_vote_tally;

  localparam int N_CAND       = 4;
  localparam int CNT_W        = 4;
  localparam int DEBOUNCE_CYC = 4;
  localparam int IDX_W        = 2;
  localparam int TOT_W        = 6;

  logic              clk;
  logic              reset;
  logic [N_CAND-1:0] btn;
  logic              vote_en;
  logic [N_CAND-1:0] sel;
  logic [CNT_W-1:0]  disp_out;
  logic [TOT_W-1:0]  total_votes;
  logic [IDX_W-1:0]  leader_idx;
  logic              leader_valid;
  logic              tie;
  logic [N_CAND-1:0] sat;
  logic [N_CAND-1:0] vote_pulse;

  int compareCount;
  int mismatchCount;
  int pulseCount [N_CAND];
  int sameEdgeCount;

  vote_tally #(
    .N_CAND      (N_CAND),
    .CNT_W       (CNT_W),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .vote_en     (vote_en),
    .sel         (sel),
    .disp_out    (disp_out),
    .total_votes (total_votes),
    .leader_idx  (leader_idx),
    .leader_valid(leader_valid),
    .tie         (tie),
    .sat         (sat),
    .vote_pulse  (vote_pulse)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse monitor: tallies counted-vote pulses and the cycles where
  // candidates 0 and 2 pulse together; cleared while reset is held.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CAND; i++) pulseCount[i] = 0;
      sameEdgeCount = 0;
    end else begin
      for (int i = 0; i < N_CAND; i++) begin
        if (vote_pulse[i]) pulseCount[i] = pulseCount[i] + 1;
      end
      if (vote_pulse[0] && vote_pulse[2]) sameEdgeCount = sameEdgeCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compareCount = compareCount + 1;
    if (got !== exp) begin
      mismatchCount = mismatchCount + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the given button mask for 'hold' cycles, release, then idle.
  task automatic applyStimulus(input logic [N_CAND-1:0] mask, input int hold,
                               input int gap);
    btn = mask;
    waitCycles(hold);
    btn = '0;
    waitCycles(gap);
  endtask

  task automatic doReset();
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(1);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    sameEdgeCount = 0;
    for (int i = 0; i < N_CAND; i++) pulseCount[i] = 0;
    reset   = 1'b1;
    btn     = '0;
    vote_en = 1'b1;
    sel     = '0;
    waitCycles(3);

    // Reset state.
    checkOutput("rst_disp", 32'(disp_out), 0);
    checkOutput("rst_total", 32'(total_votes), 0);
    checkOutput("rst_valid", 32'(leader_valid), 0);
    checkOutput("rst_sat", 32'(sat), 0);
    reset = 1'b0;
    waitCycles(1);

    // Glitch of three synchronised cycles: nothing counts.
    applyStimulus(4'b0001, 3, 6);
    checkOutput("glitch_pulse0", 32'(pulseCount[0]), 0);
    checkOutput("glitch_total", 32'(total_votes), 0);
    checkOutput("glitch_valid", 32'(leader_valid), 0);

    // Long hold then a short re-press on candidate 1: two votes.
    applyStimulus(4'b0010, 20, 6);
    applyStimulus(4'b0010, 6, 6);
    checkOutput("c1_pulses", 32'(pulseCount[1]), 2);
    checkOutput("c1_total", 32'(total_votes), 2);
    checkOutput("c1_leader", 32'(leader_idx), 1);
    checkOutput("c1_tie", 32'(tie), 0);
    checkOutput("c1_valid", 32'(leader_valid), 1);
    sel = 4'b0010;
    waitCycles(2);
    checkOutput("c1_disp", 32'(disp_out), 2);
    sel = 4'b0110;
    waitCycles(2);
    checkOutput("c1_disp_lowbit", 32'(disp_out), 2);
    sel = '0;

    // Simultaneous presses on candidates 0 and 2.
    doReset();
    applyStimulus(4'b0101, 6, 6);
    checkOutput("sim_same_edge", 32'(sameEdgeCount), 1);
    checkOutput("sim_pulse0", 32'(pulseCount[0]), 1);
    checkOutput("sim_pulse2", 32'(pulseCount[2]), 1);
    checkOutput("sim_total", 32'(total_votes), 2);
    checkOutput("sim_tie", 32'(tie), 1);
    checkOutput("sim_leader", 32'(leader_idx), 0);

    // Saturation on candidate 3.
    doReset();
    for (int p = 0; p < 15; p++) applyStimulus(4'b1000, 5, 4);
    checkOutput("sat15_pulses", 32'(pulseCount[3]), 15);
    checkOutput("sat15_flag", 32'(sat), 0);
    for (int p = 0; p < 2; p++) applyStimulus(4'b1000, 5, 4);
    checkOutput("sat17_pulses", 32'(pulseCount[3]), 15);
    checkOutput("sat17_flag", 32'(sat), 32'h8);
    checkOutput("sat17_total", 32'(total_votes), 15);
    checkOutput("sat17_disp", 32'(disp_out), 15);
    checkOutput("sat17_leader", 32'(leader_idx), 3);
    applyStimulus(4'b0001, 6, 6);
    checkOutput("sat_total16", 32'(total_votes), 16);
    checkOutput("sat_disp_clamp", 32'(disp_out), 15);
    checkOutput("sat_tie", 32'(tie), 0);

    // Press accepted while voting is closed is lost, even if held on.
    doReset();
    vote_en = 1'b0;
    btn     = 4'b0100;
    waitCycles(10);
    vote_en = 1'b1;
    waitCycles(6);
    checkOutput("closed_pulses", 32'(pulseCount[2]), 0);
    checkOutput("closed_total", 32'(total_votes), 0);
    checkOutput("closed_valid", 32'(leader_valid), 0);
    btn = '0;
    waitCycles(6);
    applyStimulus(4'b0100, 6, 6);
    checkOutput("reopen_pulses", 32'(pulseCount[2]), 1);
    checkOutput("reopen_total", 32'(total_votes), 1);
    checkOutput("reopen_leader", 32'(leader_idx), 2);

    // Asynchronous reset in the middle of a press.
    doReset();
    applyStimulus(4'b0010, 6, 6);
    sel = 4'b0010;
    waitCycles(2);
    checkOutput("pre_rst_disp", 32'(disp_out), 1);
    btn = 4'b0010;
    waitCycles(4);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_disp", 32'(disp_out), 0);
    checkOutput("async_total", 32'(total_votes), 0);
    checkOutput("async_valid", 32'(leader_valid), 0);
    checkOutput("async_pulse", 32'(vote_pulse), 0);
    btn = '0;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(2);
    applyStimulus(4'b0010, 6, 6);
    checkOutput("post_rst_pulses", 32'(pulseCount[1]), 1);
    checkOutput("post_rst_total", 32'(total_votes), 1);
    checkOutput("post_rst_disp", 32'(disp_out), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount,
             mismatchCount);
    $finish;
  end

endmodule
